spi_regfile_slave: RTL and testbench

SPI mode-0 slave exposing a parametrised register file to an external SPI master. It replaces the earlier bit-addressed, single-byte command block with byte-wide registers, burst reads and writes with address auto-increment, and a read-only status bank. All SPI pins are oversampled in the system clock domain, so there is a single clock and no logic clocked by the SPI clock. It sits between the microcontroller/JTAG-bridge SPI pins and board control logic such as LEDs and test-mode controls.

---
 rtl/spi_regfile_slave.sv | 204 ++++++++++++++++++++
 tb/tb_spi_regfile_slave.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_slave.sv
// SPI mode-0 slave giving an external master burst access to a byte-wide register file.
// All SPI pins are oversampled in input_clk; nothing is clocked by the SPI clock.
`timescale 1ns/1ps

module spi_regfile_slave #(
  parameter int          ADDR_W   = 4,
  parameter int          NUM_RW   = 8,
  parameter int          NUM_RO   = 4,
  parameter logic [7:0]  RW_RESET = 8'h00,
  parameter logic [7:0]  ID_BYTE  = 8'hA5
) (
  input  logic                  input_clk,
  input  logic                  input_rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_ss,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [NUM_RW*8-1:0]   reg_out,
  input  logic [NUM_RO*8-1:0]   status_in,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  rd_strobe,
  output logic [ADDR_W-1:0]     rd_addr
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  logic sckMeta_q, sckSync_q, sckHist_q, sckRise_q, sckFall_q;
  logic mosiMeta_q, mosiSync_q, mosi_q;
  logic ssMeta_q, ssSync_q, ssHist_q, ssFall_q;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [6:0]          shiftIn_q, shiftIn_d;
  logic [7:0]          shiftOut_q, shiftOut_d;
  logic                miso_q, miso_d;
  logic                oe_q, oe_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          regs_q [NUM_RW];
  logic [7:0]          regs_d [NUM_RW];
  logic                wrStrobe_q, wrStrobe_d;
  logic                rdStrobe_q, rdStrobe_d;
  logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0]   rdAddr_q, rdAddr_d;

  logic [7:0]          byteIn;
  logic [ADDR_W-1:0]   cmdAddr;

  function automatic logic [7:0] readData(input logic [ADDR_W-1:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_RW; i++)
      if (a == ADDR_W'(i)) r = regs_q[i];
    for (int j = 0; j < NUM_RO; j++)
      if (a == ADDR_W'(NUM_RW + j)) r = status_in[8*j +: 8];
    return r;
  endfunction

  // The ss chain resets to "selected" so that a slave select already held low
  // across reset release never looks like a fresh falling edge.
  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      sckMeta_q  <= 1'b0;
      sckSync_q  <= 1'b0;
      sckHist_q  <= 1'b0;
      sckRise_q  <= 1'b0;
      sckFall_q  <= 1'b0;
      mosiMeta_q <= 1'b0;
      mosiSync_q <= 1'b0;
      mosi_q     <= 1'b0;
      ssMeta_q   <= 1'b0;
      ssSync_q   <= 1'b0;
      ssHist_q   <= 1'b0;
      ssFall_q   <= 1'b0;
    end else begin
      sckMeta_q  <= spi_clk;
      sckSync_q  <= sckMeta_q;
      sckHist_q  <= sckSync_q;
      sckRise_q  <= sckSync_q & ~sckHist_q;
      sckFall_q  <= ~sckSync_q & sckHist_q;
      mosiMeta_q <= spi_mosi;
      mosiSync_q <= mosiMeta_q;
      mosi_q     <= mosiSync_q;
      ssMeta_q   <= spi_ss;
      ssSync_q   <= ssMeta_q;
      ssHist_q   <= ssSync_q;
      ssFall_q   <= ~ssSync_q & ssHist_q;
    end
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shiftIn_q  <= 7'd0;
      shiftOut_q <= 8'h00;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      wrStrobe_q <= 1'b0;
      rdStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
      rdAddr_q   <= '0;
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= RW_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shiftIn_q  <= shiftIn_d;
      shiftOut_q <= shiftOut_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      wrStrobe_q <= wrStrobe_d;
      rdStrobe_q <= rdStrobe_d;
      wrAddr_q   <= wrAddr_d;
      rdAddr_q   <= rdAddr_d;
      regs_q     <= regs_d;
    end
  end

  // shiftOut_q holds the bits not yet presented on MISO, so a reload made at
  // byte completion is presented (bit 7 first) at the very next SCK fall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shiftIn_d  = shiftIn_q;
    shiftOut_d = shiftOut_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    addr_d     = addr_q;
    regs_d     = regs_q;
    wrStrobe_d = 1'b0;
    rdStrobe_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    rdAddr_d   = rdAddr_q;
    byteIn     = {shiftIn_q, mosi_q};
    cmdAddr    = byteIn[ADDR_W-1:0];

    if (ssHist_q) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else if (ssFall_q) begin
      state_d    = CMD;
      cnt_d      = 3'd0;
      shiftOut_d = {ID_BYTE[6:0], 1'b0};
      miso_d     = ID_BYTE[7];
      oe_d       = 1'b1;
    end else if (state_q != IDLE) begin
      if (sckRise_q) begin
        shiftIn_d = byteIn[6:0];
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              if (byteIn[7]) begin
                addr_d  = cmdAddr;
                state_d = WDATA;
              end else begin
                shiftOut_d = readData(cmdAddr);
                rdStrobe_d = 1'b1;
                rdAddr_d   = cmdAddr;
                addr_d     = cmdAddr + ADDR_W'(1);
                state_d    = RDATA;
              end
            end
            WDATA: begin
              if (int'(addr_q) < NUM_RW) begin
                for (int i = 0; i < NUM_RW; i++)
                  if (addr_q == ADDR_W'(i)) regs_d[i] = byteIn;
                wrStrobe_d = 1'b1;
                wrAddr_d   = addr_q;
              end
              addr_d = addr_q + ADDR_W'(1);
            end
            RDATA: begin
              shiftOut_d = readData(addr_q);
              rdStrobe_d = 1'b1;
              rdAddr_d   = addr_q;
              addr_d     = addr_q + ADDR_W'(1);
            end
            default: ;
          endcase
        end
      end else if (sckFall_q) begin
        miso_d     = shiftOut_q[7];
        shiftOut_d = {shiftOut_q[6:0], 1'b0};
      end
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_regOut
    assign reg_out[8*g +: 8] = regs_q[g];
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign wr_strobe   = wrStrobe_q;
  assign wr_addr     = wrAddr_q;
  assign rd_strobe   = rdStrobe_q;
  assign rd_addr     = rdAddr_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed bench for spi_regfile_slave: a bench-side SPI master plus an
// address-level register-file model checked against the DUT every cycle.
`timescale 1ns/1ps

module tb_spi_regfile_slave;

  localparam int ADDR_W = 4;
  localparam int NUM_RW = 8;
  localparam int NUM_RO = 4;
  localparam int ASPACE = 1 << ADDR_W;

  logic                input_clk = 1'b0;
  logic                input_rst_n;
  logic                spi_clk, spi_mosi, spi_ss;
  logic                spi_miso, spi_miso_oe;
  logic [NUM_RW*8-1:0] reg_out;
  logic [NUM_RO*8-1:0] status_in;
  logic                wr_strobe, rd_strobe;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;

  spi_regfile_slave #(
    .ADDR_W(ADDR_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO),
    .RW_RESET(8'h00), .ID_BYTE(8'hA5)
  ) dut (
    .input_clk(input_clk), .input_rst_n(input_rst_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_ss(spi_ss),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_out(reg_out), .status_in(status_in),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .rd_strobe(rd_strobe), .rd_addr(rd_addr)
  );

  always #5 input_clk = ~input_clk;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         wrSeen = 0;
  int         rdSeen = 0;
  bit         modelSync = 1'b0;
  logic [7:0] modelRegs [NUM_RW];
  int         wrQ [$];
  int         rdQ [$];
  logic [7:0] txBuf [16];
  logic [7:0] rxBuf [16];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] modelRdata(input int a);
    if (a < NUM_RW) return modelRegs[a];
    if (a < NUM_RW + NUM_RO) return status_in[8*(a-NUM_RW) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [63:0] modelPacked();
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < NUM_RW; i++) p[8*i +: 8] = modelRegs[i];
    return p;
  endfunction

  // Strobes are matched against the queued model expectations; register
  // contents and the idle MISO enable are checked whenever no transfer is open.
  always @(negedge input_clk) begin
    if (input_rst_n) begin
      if (wr_strobe || rd_strobe)
        checkOutput("strobe_exclusive", 64'(wr_strobe & rd_strobe), 64'd0);
      if (wr_strobe) begin
        wrSeen++;
        if (wrQ.size() == 0) checkOutput("wr_strobe_unexpected", 64'd1, 64'd0);
        else checkOutput("wr_addr", 64'(wr_addr), 64'(wrQ.pop_front()));
      end
      if (rd_strobe) begin
        rdSeen++;
        if (rdQ.size() == 0) checkOutput("rd_strobe_unexpected", 64'd1, 64'd0);
        else checkOutput("rd_addr", 64'(rd_addr), 64'(rdQ.pop_front()));
      end
      if (modelSync) begin
        checkOutput("reg_out", reg_out, modelPacked());
        checkOutput("miso_oe_idle", 64'(spi_miso_oe), 64'd0);
      end
    end
  end

  task automatic spiByte(input logic [7:0] tx, input int nBits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      spi_mosi = tx[7-i];
      #40;
      rx = {rx[6:0], spi_miso};
      spi_clk = 1'b1;
      #40;
      spi_clk = 1'b0;
    end
  endtask

  // One framed transfer of txBuf[0..nBytes-1] plus an optional partial byte.
  // Model effects are queued before each byte because the DUT acts during its last clock phase.
  task automatic applyStimulus(input int nBytes, input int extraBits);
    int         addr;
    bit         isWrite;
    logic [7:0] rx, expRx, expCur;
    modelSync = 1'b0;
    @(posedge input_clk);
    #($urandom_range(1, 9));
    spi_ss = 1'b0;
    #100;
    checkOutput("miso_oe_active", 64'(spi_miso_oe), 64'd1);
    isWrite = txBuf[0][7];
    addr    = int'(txBuf[0][ADDR_W-1:0]);
    expRx   = 8'hA5;
    for (int b = 0; b < nBytes; b++) begin
      expCur = expRx;
      if (isWrite) begin
        if (b > 0) begin
          if (addr < NUM_RW) begin
            modelRegs[addr] = txBuf[b];
            wrQ.push_back(addr);
          end
          addr = (addr + 1) % ASPACE;
        end
        expRx = 8'h00;
      end else begin
        expRx = modelRdata(addr);
        rdQ.push_back(addr);
        addr = (addr + 1) % ASPACE;
      end
      spiByte(txBuf[b], 8, rx);
      rxBuf[b] = rx;
      checkOutput($sformatf("miso_byte%0d", b), 64'(rx), 64'(expCur));
    end
    if (extraBits > 0) spiByte(txBuf[nBytes], extraBits, rx);
    #60;
    spi_ss = 1'b1;
    #100;
    checkOutput("wr_pending", 64'(wrQ.size()), 64'd0);
    checkOutput("rd_pending", 64'(rdQ.size()), 64'd0);
    modelSync = 1'b1;
  endtask

  initial begin
    int         w0, r0;
    logic [7:0] rx;
    logic [7:0] wrData [4];
    input_rst_n = 1'b0;
    spi_clk     = 1'b0;
    spi_mosi    = 1'b0;
    spi_ss      = 1'b1;
    status_in   = 32'h5A00_3CC3;
    for (int i = 0; i < NUM_RW; i++) modelRegs[i] = 8'h00;

    #23;
    checkOutput("rst_reg_out", reg_out, 64'd0);
    checkOutput("rst_wr_strobe", 64'(wr_strobe), 64'd0);
    checkOutput("rst_rd_strobe", 64'(rd_strobe), 64'd0);
    checkOutput("rst_miso", 64'(spi_miso), 64'd0);
    checkOutput("rst_miso_oe", 64'(spi_miso_oe), 64'd0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_rd_addr", 64'(rd_addr), 64'd0);
    #20 input_rst_n = 1'b1;
    #50 modelSync = 1'b1;

    w0 = wrSeen;
    txBuf[0] = 8'h82; txBuf[1] = 8'h5C;
    applyStimulus(2, 0);
    checkOutput("single_reg2", 64'(reg_out[23:16]), 64'h5C);
    checkOutput("single_id", 64'(rxBuf[0]), 64'hA5);
    checkOutput("single_wr_count", 64'(wrSeen - w0), 64'd1);

    w0 = wrSeen;
    txBuf[0] = 8'h8E; txBuf[1] = 8'h11; txBuf[2] = 8'h22; txBuf[3] = 8'h33;
    applyStimulus(4, 0);
    checkOutput("wrap_reg0", 64'(reg_out[7:0]), 64'h33);
    checkOutput("wrap_wr_count", 64'(wrSeen - w0), 64'd1);

    txBuf[0] = 8'h87; txBuf[1] = 8'h77;
    applyStimulus(2, 0);
    r0 = rdSeen;
    txBuf[0] = 8'h07;
    for (int k = 1; k < 5; k++) txBuf[k] = 8'hE0 + 8'(k);
    applyStimulus(5, 0);
    checkOutput("bank_rd1", 64'(rxBuf[1]), 64'h77);
    checkOutput("bank_rd2", 64'(rxBuf[2]), 64'hC3);
    checkOutput("bank_rd3", 64'(rxBuf[3]), 64'h3C);
    checkOutput("bank_rd4", 64'(rxBuf[4]), 64'h00);
    checkOutput("bank_rd_count", 64'(rdSeen - r0), 64'd5);

    txBuf[0] = 8'h0E; txBuf[1] = 8'hFF; txBuf[2] = 8'hFF; txBuf[3] = 8'hFF;
    applyStimulus(4, 0);
    checkOutput("unmapped_rd14", 64'(rxBuf[1]), 64'h00);
    checkOutput("unmapped_rd15", 64'(rxBuf[2]), 64'h00);
    checkOutput("wrap_rd0", 64'(rxBuf[3]), 64'h33);

    w0 = wrSeen;
    txBuf[0] = 8'h89; txBuf[1] = 8'hFF;
    applyStimulus(2, 0);
    checkOutput("ro_write_regs", reg_out, 64'h7700_0000_005C_0033);
    txBuf[0] = 8'h83; txBuf[1] = 8'hAB;
    applyStimulus(1, 5);
    checkOutput("abort_reg3", 64'(reg_out[31:24]), 64'h00);
    checkOutput("illegal_abort_wr_count", 64'(wrSeen - w0), 64'd0);

    modelSync = 1'b0;
    @(posedge input_clk);
    #3 spi_ss = 1'b0;
    #100;
    modelRegs[1] = 8'h99;
    wrQ.push_back(1);
    spiByte(8'h81, 8, rx);
    spiByte(8'h99, 8, rx);
    spiByte(8'h42, 3, rx);
    #100;
    checkOutput("pre_reset_reg1", 64'(reg_out[15:8]), 64'h99);
    input_rst_n = 1'b0;
    #20;
    for (int i = 0; i < NUM_RW; i++) modelRegs[i] = 8'h00;
    wrQ.delete();
    rdQ.delete();
    checkOutput("midrst_reg_out", reg_out, 64'd0);
    checkOutput("midrst_wr_strobe", 64'(wr_strobe), 64'd0);
    checkOutput("midrst_rd_strobe", 64'(rd_strobe), 64'd0);
    checkOutput("midrst_miso_oe", 64'(spi_miso_oe), 64'd0);
    #20 input_rst_n = 1'b1;
    #40;
    w0 = wrSeen;
    spiByte(8'h85, 8, rx);
    spiByte(8'h77, 8, rx);
    #60;
    checkOutput("post_rst_oe_held", 64'(spi_miso_oe), 64'd0);
    checkOutput("post_rst_no_write", 64'(wrSeen - w0), 64'd0);
    spi_ss = 1'b1;
    #100;
    modelSync = 1'b1;
    txBuf[0] = 8'h84; txBuf[1] = 8'h3C;
    applyStimulus(2, 0);
    checkOutput("post_rst_reg4", 64'(reg_out[39:32]), 64'h3C);

    for (int n = 0; n < 100; n++) begin
      int start, len;
      start = $urandom_range(0, NUM_RW - 1);
      len   = $urandom_range(1, 3);
      txBuf[0] = {1'b1, 7'(start)};
      for (int k = 0; k < len; k++) begin
        wrData[k]  = 8'($urandom);
        txBuf[k+1] = wrData[k];
      end
      applyStimulus(len + 1, 0);
      txBuf[0] = {1'b0, 7'(start)};
      for (int k = 1; k <= len; k++) txBuf[k] = 8'($urandom);
      applyStimulus(len + 1, 0);
      for (int k = 0; k < len; k++)
        if (start + k < NUM_RW)
          checkOutput($sformatf("readback_a%0d", start + k), 64'(rxBuf[k+1]), 64'(wrData[k]));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
